// File: rtl/bp_pkg.sv
// Shared types for branch resolution and predictor training records.
package bp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Training-record FIFO: head visible 1 cycle after push, valid/ready pop,
// push accepted when full only if a pop happens in the same cycle.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_push,
  input  bp_upd_t i_push_dat,
  output logic    o_pop_vld,
  input  logic    i_pop_rdy,
  output bp_upd_t o_pop_dat,
  output logic    o_full,
  output logic    o_empty
);

  localparam int PW = $clog2(DEPTH);

  bp_upd_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          pop;
  logic          push_acc;

  assign o_empty   = (cnt_q == '0);
  assign o_full    = (cnt_q == (PW+1)'(DEPTH));
  assign o_pop_vld = ~o_empty;
  assign o_pop_dat = o_empty ? '0 : mem_q[rd_ptr_q];
  assign pop       = o_pop_vld & i_pop_rdy;
  // a pop frees the head slot this edge, so a full queue can still take the push
  assign push_acc  = i_push & (~o_full | pop);

  always_comb begin
    wr_ptr_d = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_acc && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push_acc && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_acc) mem_q[wr_ptr_q] <= i_push_dat;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX control flow: zero-latency flush/redirect on mispredict, best-effort
// predictor training queue (drops when full, never stalls), saturating perf counters.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int UQ_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_valid_ex,
  input  logic             i_is_ctrl_ex,
  input  logic [31:0]      i_pc_ex,
  input  logic             i_pred_taken_ex,
  input  logic [31:0]      i_pred_target_ex,
  input  logic             i_actual_taken,
  input  logic [31:0]      i_target_addr,
  output logic             o_flush,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_upd_valid,
  input  logic             i_upd_ready,
  output logic [31:0]      o_upd_pc,
  output logic             o_upd_taken,
  output logic [31:0]      o_upd_target,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  logic        resolve;
  logic        mispred;
  logic [31:0] actual_pc;
  logic        q_full;
  logic        q_empty;
  logic        pop;
  logic        drop;
  bp_upd_t     enq_dat;
  bp_upd_t     head_dat;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign resolve   = i_valid_ex & i_is_ctrl_ex & ~i_stall & ~i_reset;
  assign actual_pc = i_actual_taken ? i_target_addr : fallthrough_pc(i_pc_ex);
  // a taken/taken pair still mispredicts if IF fetched from the wrong target
  assign mispred   = resolve & ((i_pred_taken_ex != i_actual_taken) |
                                (i_pred_taken_ex & i_actual_taken &
                                 (i_pred_target_ex != i_target_addr)));

  assign o_flush          = mispred;
  assign o_redirect_valid = mispred;
  assign o_redirect_pc    = mispred ? actual_pc : 32'd0;

  assign enq_dat = '{pc: i_pc_ex, taken: i_actual_taken, target: i_target_addr};
  assign pop     = o_upd_valid & i_upd_ready;
  assign drop    = resolve & q_full & ~pop;

  bp_upd_fifo #(.DEPTH(UQ_DEPTH)) u_upd_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (resolve),
    .i_push_dat (enq_dat),
    .o_pop_vld  (o_upd_valid),
    .i_pop_rdy  (i_upd_ready),
    .o_pop_dat  (head_dat),
    .o_full     (q_full),
    .o_empty    (q_empty)
  );

  assign o_upd_pc     = head_dat.pc;
  assign o_upd_taken  = head_dat.taken;
  assign o_upd_target = head_dat.target;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    if (resolve && !(&branch_cnt_q))  branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mispred && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    if (drop && !(&drop_cnt_q))       drop_cnt_d    = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
  assign o_drop_cnt    = drop_cnt_q;

  logic unused_empty;
  assign unused_empty = q_empty;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; training records checked through a scoreboard queue.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_stall, i_valid_ex, i_is_ctrl_ex;
  logic [31:0] i_pc_ex, i_pred_target_ex, i_target_addr;
  logic        i_pred_taken_ex, i_actual_taken, i_upd_ready;
  logic        o_flush, o_redirect_valid, o_upd_valid, o_upd_taken;
  logic [31:0] o_redirect_pc, o_upd_pc, o_upd_target;
  logic [31:0] o_branch_cnt, o_mispred_cnt, o_drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [64:0] expq[$];
  logic        hold_q = 1'b0;
  logic [64:0] held_rec;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.UQ_DEPTH(4), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_valid_ex(i_valid_ex),
    .i_is_ctrl_ex(i_is_ctrl_ex), .i_pc_ex(i_pc_ex), .i_pred_taken_ex(i_pred_taken_ex),
    .i_pred_target_ex(i_pred_target_ex), .i_actual_taken(i_actual_taken),
    .i_target_addr(i_target_addr), .o_flush(o_flush), .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc), .o_upd_valid(o_upd_valid), .i_upd_ready(i_upd_ready),
    .o_upd_pc(o_upd_pc), .o_upd_taken(o_upd_taken), .o_upd_target(o_upd_target),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt), .o_drop_cnt(o_drop_cnt)
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] rec(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    return {pc, t, tg};
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks head stability under backpressure.
  always @(negedge clk) begin
    if (!i_reset) begin
      if (hold_q && o_upd_valid)
        chk("upd_stable", {o_upd_pc, o_upd_taken, o_upd_target}, held_rec);
      if (o_upd_valid && i_upd_ready) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL upd_unexpected: got %0h expected none", {o_upd_pc, o_upd_taken, o_upd_target});
        end else begin
          chk("upd_rec", {o_upd_pc, o_upd_taken, o_upd_target}, expq.pop_front());
        end
      end
      hold_q   = o_upd_valid & ~i_upd_ready;
      held_rec = {o_upd_pc, o_upd_taken, o_upd_target};
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic drive(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic at, input logic [31:0] tg, input logic stall);
    @(posedge clk); #1;
    i_valid_ex = 1'b1; i_is_ctrl_ex = 1'b1; i_stall = stall;
    i_pc_ex = pc; i_pred_taken_ex = pt; i_pred_target_ex = ptg;
    i_actual_taken = at; i_target_addr = tg;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid_ex = 1'b0; i_stall = 1'b0;
  endtask

  task automatic chk_redir(input string name, input logic fl, input logic [31:0] pc);
    @(negedge clk);
    chk({name, "_flush"}, 65'(o_flush), 65'(fl));
    chk({name, "_rvalid"}, 65'(o_redirect_valid), 65'(fl));
    chk({name, "_rpc"}, 65'(o_redirect_pc), 65'(pc));
  endtask

  task automatic chk_cnt(input string name, input int b, input int m, input int d);
    @(negedge clk);
    chk({name, "_branch"}, 65'(o_branch_cnt), 65'(b));
    chk({name, "_mispred"}, 65'(o_mispred_cnt), 65'(m));
    chk({name, "_drop"}, 65'(o_drop_cnt), 65'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_valid_ex = 1'b0; i_is_ctrl_ex = 1'b0;
    i_pc_ex = '0; i_pred_taken_ex = 1'b0; i_pred_target_ex = '0;
    i_actual_taken = 1'b0; i_target_addr = '0; i_upd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
    chk_cnt("reset", 0, 0, 0);
    chk("reset_updv", 65'(o_upd_valid), 65'd0);

    // correct not-taken prediction; record only visible the following cycle
    drive(32'h100, 1'b0, 32'h104, 1'b0, 32'h180, 1'b0);
    expq.push_back(rec(32'h100, 1'b0, 32'h180));
    chk_redir("nt_ok", 1'b0, 32'h0);
    chk("no_bypass", 65'(o_upd_valid), 65'd0);
    idle();
    chk_cnt("nt_ok", 1, 0, 0);
    chk("nt_updv", 65'(o_upd_valid), 65'd1);
    idle();
    @(negedge clk);
    chk("empty_zero", {o_upd_valid, o_upd_pc, o_upd_target}, 65'd0);

    // direction mispredicts
    drive(32'h200, 1'b0, 32'h204, 1'b1, 32'h80, 1'b0);
    expq.push_back(rec(32'h200, 1'b1, 32'h80));
    chk_redir("dir_nt_t", 1'b1, 32'h80);
    drive(32'h300, 1'b1, 32'h500, 1'b0, 32'h500, 1'b0);
    expq.push_back(rec(32'h300, 1'b0, 32'h500));
    chk_redir("dir_t_nt", 1'b1, 32'h304);
    idle();
    chk_cnt("dir", 3, 2, 0);

    // target mispredict, then a fully correct taken branch
    drive(32'h40, 1'b1, 32'h90, 1'b1, 32'hA0, 1'b0);
    expq.push_back(rec(32'h40, 1'b1, 32'hA0));
    chk_redir("tgt", 1'b1, 32'hA0);
    drive(32'h50, 1'b1, 32'h60, 1'b1, 32'h60, 1'b0);
    expq.push_back(rec(32'h50, 1'b1, 32'h60));
    chk_redir("t_ok", 1'b0, 32'h0);
    idle();
    chk_cnt("tgt", 5, 3, 0);

    // stall gating: three stalled cycles, then one release
    for (int i = 0; i < 3; i++) begin
      drive(32'h600, 1'b0, 32'h604, 1'b1, 32'h700, 1'b1);
      chk_redir("stalled", 1'b0, 32'h0);
    end
    drive(32'h600, 1'b0, 32'h604, 1'b1, 32'h700, 1'b0);
    expq.push_back(rec(32'h600, 1'b1, 32'h700));
    chk_redir("unstall", 1'b1, 32'h700);
    idle();
    chk_cnt("stall", 6, 4, 0);
    repeat (2) idle();

    // backpressure: six resolves into four slots
    i_upd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h1000 + 32'(16 * i), 1'b0, 32'h0, 1'b0, 32'h2000 + 32'(i), 1'b0);
      if (i < 4) expq.push_back(rec(32'h1000 + 32'(16 * i), 1'b0, 32'h2000 + 32'(i)));
    end
    idle();
    chk_cnt("bp_full", 12, 4, 2);
    chk("bp_head", 65'(o_upd_pc), 65'h1000);
    // full queue: enqueue and pop in the same cycle must not drop
    drive(32'h1100, 1'b0, 32'h0, 1'b0, 32'h2100, 1'b0);
    i_upd_ready = 1'b1;
    expq.push_back(rec(32'h1100, 1'b0, 32'h2100));
    repeat (4) idle();
    chk_cnt("bp_pushpop", 13, 4, 2);
    chk("bp_last_head", 65'(o_upd_pc), 65'h1100);
    idle();
    @(negedge clk);
    chk("bp_drained", 65'(o_upd_valid), 65'd0);
    chk("bp_sb_empty", 65'(expq.size()), 65'd0);

    // reset mid-operation, with a mispredicting resolve in the reset cycle
    i_upd_ready = 1'b0;
    drive(32'h3000, 1'b0, 32'h0, 1'b1, 32'h3800, 1'b0);
    drive(32'h3010, 1'b0, 32'h0, 1'b0, 32'h3810, 1'b0);
    drive(32'h3020, 1'b0, 32'h0, 1'b0, 32'h3820, 1'b0);
    idle();
    chk_cnt("pre_rst", 16, 5, 2);
    drive(32'h4000, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    i_reset = 1'b1;
    expq.delete();
    chk_redir("in_rst", 1'b0, 32'h0);
    idle();
    i_reset = 1'b0;
    chk_cnt("post_rst", 0, 0, 0);
    chk("post_rst_upd", {o_upd_valid, o_upd_pc, o_upd_target}, 65'd0);

    // normal operation resumes after reset
    i_upd_ready = 1'b1;
    drive(32'h5000, 1'b1, 32'h5100, 1'b1, 32'h5100, 1'b0);
    expq.push_back(rec(32'h5000, 1'b1, 32'h5100));
    repeat (3) idle();
    chk_cnt("resume", 1, 0, 0);
    chk("final_sb_empty", 65'(expq.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
